mem_port_arbiter: RTL

- Shares one single-port synchronous memory between the instruction-fetch port and the load/store data port, for the unified-memory core configuration.
- Data accesses have priority by default. A starvation counter forces a fetch grant after a bounded run of data wins, so fetch always makes progress.
- Outputs a fetch-stall signal that holds the PC register and routes each read response back to the requester that issued it.

---
 rtl/mem_port_arbiter.sv | 96 +++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port synchronous memory between instruction fetch and load/store data.
// Data wins by default, with a bounded data streak. Optional perf counters: MEM_ARB_PERF_CNT_EN.
module mem_port_arbiter #(
  parameter int ADDRESS_WIDTH   = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     if_req,
  input  logic [ADDRESS_WIDTH-1:0] if_addr,
  output logic                     if_gnt,
  output logic                     if_rvalid,
  output logic [DATA_WIDTH-1:0]    if_rdata,
  output logic                     if_stall,
  input  logic                     d_req,
  input  logic                     d_we,
  input  logic [ADDRESS_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0]    d_wdata,
  output logic                     d_gnt,
  output logic                     d_rvalid,
  output logic [DATA_WIDTH-1:0]    d_rdata,
  output logic                     mem_en,
  output logic                     mem_we,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]    mem_wdata,
  input  logic [DATA_WIDTH-1:0]    mem_rdata
`ifdef MEM_ARB_PERF_CNT_EN
  ,
  output logic [31:0]              perf_if_stall_cnt,
  output logic [31:0]              perf_conflict_cnt,
  output logic [31:0]              perf_forced_if_cnt
`endif
);

  localparam int SW = $clog2(MAX_DATA_STREAK + 1);
  localparam logic [SW-1:0] SMAX = SW'(MAX_DATA_STREAK);

  logic [SW-1:0] streak_cnt;
  logic [1:0]    owner;     // {fetch read in flight, data read in flight}
  logic          forced;

  always_comb begin
    if_gnt = 1'b0;
    d_gnt  = 1'b0;
    forced = 1'b0;
    if (!rst) begin
      if (d_req && (!if_req || streak_cnt < SMAX)) begin
        d_gnt = 1'b1;
      end else if (if_req) begin
        if_gnt = 1'b1;
        forced = d_req;
      end
    end
  end

  assign if_stall  = if_req & ~if_gnt;
  assign mem_en    = if_gnt | d_gnt;
  assign mem_we    = d_gnt & d_we;
  assign mem_addr  = if_gnt ? if_addr : (d_gnt ? d_addr : '0);
  assign mem_wdata = d_gnt ? d_wdata : '0;

  // Streak only grows while fetch is actually waiting behind data.
  always_ff @(posedge clk) begin
    if (rst) begin
      streak_cnt <= '0;
      owner      <= 2'b00;
    end else begin
      if (if_req && d_gnt)
        streak_cnt <= (streak_cnt == SMAX) ? streak_cnt : streak_cnt + SW'(1);
      else
        streak_cnt <= '0;
      owner <= {if_gnt, d_gnt & ~d_we};
    end
  end

  assign if_rvalid = owner[1];
  assign d_rvalid  = owner[0];
  assign if_rdata  = owner[1] ? mem_rdata : '0;
  assign d_rdata   = owner[0] ? mem_rdata : '0;

`ifdef MEM_ARB_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_if_stall_cnt  <= '0;
      perf_conflict_cnt  <= '0;
      perf_forced_if_cnt <= '0;
    end else begin
      if (if_stall)        perf_if_stall_cnt  <= perf_if_stall_cnt + 32'd1;
      if (if_req && d_req) perf_conflict_cnt  <= perf_conflict_cnt + 32'd1;
      if (forced)          perf_forced_if_cnt <= perf_forced_if_cnt + 32'd1;
    end
  end
`endif

endmodule
